// File: rtl/video_pattern_gen.sv
// Raster timing generator with selectable Y/Cb/Cr test patterns.
// Emits one pixel per clock and feeds the filter chain.
module video_pattern_gen #(
  parameter int PIXEL_WIDTH = 8,
  parameter int H_ACTIVE    = 16,
  parameter int H_FP        = 2,
  parameter int H_SYNC      = 4,
  parameter int H_BP        = 2,
  parameter int V_ACTIVE    = 8,
  parameter int V_FP        = 1,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [1:0]             pattern_i,
  output logic [PIXEL_WIDTH-1:0] y_o,
  output logic [PIXEL_WIDTH-1:0] cb_o,
  output logic [PIXEL_WIDTH-1:0] cr_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   sof_o,
  output logic                   busy_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam logic [31:0] H_ACT  = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT  = 32'(V_ACTIVE);
  localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [PIXEL_WIDTH-1:0] MID =
    {1'b1, {(PIXEL_WIDTH-1){1'b0}}};
  localparam logic [PIXEL_WIDTH-1:0] MAX = {PIXEL_WIDTH{1'b1}};

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [HW-1:0]          h_q, h_d;
  logic [VW-1:0]          v_q, v_d;
  logic [1:0]             pat_q, pat_d;
  logic [PIXEL_WIDTH-1:0] y_q, y_d;
  logic [PIXEL_WIDTH-1:0] cb_q, cb_d;
  logic [PIXEL_WIDTH-1:0] cr_q, cr_d;
  logic                   de_q, de_d;
  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic                   sof_q, sof_d;

  logic [31:0] h32, v32;
  logic        h_last, v_last, act;

  assign h32    = 32'(h_q);
  assign v32    = 32'(v_q);
  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    pat_d   = pat_q;
    y_d     = '0;
    cb_d    = '0;
    cr_d    = '0;
    de_d    = 1'b0;
    hs_d    = 1'b0;
    vs_d    = 1'b0;
    sof_d   = 1'b0;
    act     = 1'b0;
    unique case (1'b1)
      (state_q == RUN): begin
        h_d = h_last ? '0 : h_q + 1'b1;
        if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
        // frame boundary: the only point where pattern/run may change
        if (h_last && v_last) begin
          if (en_i) pat_d = pattern_i;
          else      state_d = IDLE;
        end
        act   = (h32 < H_ACT) && (v32 < V_ACT);
        de_d  = act;
        hs_d  = (h32 >= HS_BEG) && (h32 < HS_END);
        vs_d  = (v32 >= VS_BEG) && (v32 < VS_END);
        sof_d = (h32 == '0) && (v32 == '0);
        if (act) begin
          cb_d = MID;
          cr_d = MID;
          unique case (pat_q)
            2'd0:    y_d = MID;
            2'd1:    y_d = h32[PIXEL_WIDTH-1:0];
            2'd2:    y_d = v32[PIXEL_WIDTH-1:0];
            default: y_d = (h32[3] ^ v32[3]) ? MAX : '0;
          endcase
        end
      end
      default: begin
        h_d = '0;
        v_d = '0;
        if (en_i) begin
          pat_d   = pattern_i;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      pat_q   <= '0;
      y_q     <= '0;
      cb_q    <= '0;
      cr_q    <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pat_q   <= pat_d;
      y_q     <= y_d;
      cb_q    <= cb_d;
      cr_q    <= cr_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      sof_q   <= sof_d;
    end
  end

  assign y_o    = y_q;
  assign cb_o   = cb_q;
  assign cr_o   = cr_q;
  assign de_o   = de_q;
  assign hs_o   = hs_q;
  assign vs_o   = vs_q;
  assign sof_o  = sof_q;
  assign busy_o = (state_q == RUN);

endmodule
